muldiv_sequencer: RTL

Iterative multiply/divide sequencer owning the HI/LO register pair for the MIPS R2000 pipeline. It accepts MULT/MULTU/DIV/DIVU operands from the ID/EX boundary and runs a 32-step shift-add multiply or restoring divide. It exports a stall request that the decode-stage hazard logic ORs into its PC/IF hold when a dependent instruction arrives while a computation is in flight. It also services MTHI/MTLO writes and feeds HI/LO to the MFHI/MFLO path.

---
 rtl/muldiv_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative 32-step multiply/divide unit owning HI/LO, with pipeline stall request
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mf_req,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             hold
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state;
    logic [CW-1:0] count;
    logic [2*WIDTH-1:0] prod, step_mul, step_div, prod_fix;
    logic [WIDTH-1:0] opnd, mag_a, mag_b, quo, rem, fix_hi, fix_lo;
    logic [WIDTH:0] add_sum, sub_trial;
    logic is_div, neg_q, neg_r, b_zero, sgn_a, sgn_b;
    assign sgn_a = ~op[0] & src_a[WIDTH-1];
    assign sgn_b = ~op[0] & src_b[WIDTH-1];
    assign mag_a = sgn_a ? -src_a : src_a;
    assign mag_b = sgn_b ? -src_b : src_b;
    assign add_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    assign step_mul = {add_sum, prod[WIDTH-1:1]};
    assign sub_trial = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]} - {1'b0, opnd};
    assign step_div = sub_trial[WIDTH] ? {prod[2*WIDTH-2:0], 1'b0}
                                       : {sub_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    assign quo = prod[WIDTH-1:0];
    assign rem = prod[2*WIDTH-1:WIDTH];
    assign prod_fix = neg_q ? -prod : prod;
    assign fix_hi = is_div ? (neg_r ? -rem : rem) : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo = is_div ? (b_zero ? '1 : (neg_q ? -quo : quo)) : prod_fix[WIDTH-1:0];
    assign hold = busy & (start | mf_req | mt_hi | mt_lo);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            prod   <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        count  <= '0;
                        is_div <= op[1];
                        neg_q  <= sgn_a ^ sgn_b;
                        neg_r  <= sgn_a;
                        b_zero <= src_b == '0;
                        prod   <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
                        opnd   <= op[1] ? mag_b : mag_a;
                    end else begin
                        if (mt_hi) hi <= mt_data;
                        if (mt_lo) lo <= mt_data;
                    end
                end
                CALC: begin
                    prod  <= is_div ? step_div : step_mul;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
